// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_burst_reader
//  Description : Drains an upstream FIFO in fixed-length packets once the
//                FIFO leaves almost-empty. Words are presented on a
//                registered valid/ready/last stream, with out_last on the
//                final beat. A read is never issued to an empty FIFO.
//                Optional macro FIFO_BURST_READER_TIMEOUT_EN adds an idle
//                timeout. Residual words below the threshold are then
//                flushed as single-beat packets.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_reader #(
    parameter int WIDTH          = 32,
    parameter int BURST_LEN      = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             async_reset_n,
    input  logic [WIDTH-1:0] fifo_rd_data,
    input  logic             fifo_empty,
    input  logic             fifo_almost_empty,
    output logic             fifo_rd_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             burst_active
);

    localparam int c_BEAT_W = $clog2(BURST_LEN + 1);

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1
`ifdef FIFO_BURST_READER_TIMEOUT_EN
        ,
        S_FLUSH = 2'd2
`endif
    } state_t;

    state_t               r_state;
    logic [c_BEAT_W-1:0]  r_beat_cnt;
    logic [WIDTH-1:0]     r_out_data;
    logic                 r_out_valid;
    logic                 r_out_last;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    logic [c_TO_W-1:0]    r_timeout_cnt;
`endif

    logic w_draining;
    logic w_slot_free;
    logic w_pop;
    logic w_final_beat;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    assign w_draining   = (r_state == S_BURST) || (r_state == S_FLUSH);
    // A flush is always a single-beat packet
    assign w_final_beat = (r_state == S_FLUSH) || (r_beat_cnt == c_BEAT_W'(1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_draining   = (r_state == S_BURST);
    assign w_final_beat = (r_beat_cnt == c_BEAT_W'(1));
`endif

    // The output register can take a word when it is empty or draining this cycle.
    // The empty check guarantees the FIFO count can never underflow.
    assign w_slot_free  = !r_out_valid || out_ready;
    assign w_pop        = w_draining && w_slot_free && !fifo_empty;

    assign fifo_rd_en   = w_pop;
    assign burst_active = w_draining;
    assign out_data     = r_out_data;
    assign out_valid    = r_out_valid;
    assign out_last     = r_out_last;

    // Packet sequencing: wait for threshold, count beats, optional idle flush
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_state    <= S_IDLE;
            r_beat_cnt <= '0;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
            r_timeout_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!fifo_almost_empty) begin
                        r_state    <= S_BURST;
                        r_beat_cnt <= c_BEAT_W'(BURST_LEN);
`ifdef FIFO_BURST_READER_TIMEOUT_EN
                        r_timeout_cnt <= '0;
                    end else if (fifo_empty) begin
                        r_timeout_cnt <= '0;
                    end else if (r_timeout_cnt == c_TO_LAST) begin
                        // Counter stays expired so residual words keep draining
                        r_state <= S_FLUSH;
                    end else begin
                        r_timeout_cnt <= r_timeout_cnt + c_TO_W'(1);
`endif
                    end
                end
                S_BURST: begin
                    if (w_pop) begin
                        r_beat_cnt <= r_beat_cnt - c_BEAT_W'(1);
                        if (w_final_beat) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
`ifdef FIFO_BURST_READER_TIMEOUT_EN
                S_FLUSH: begin
                    if (w_pop) begin
                        r_state <= S_IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output stage: load on pop, hold while stalled, empty once accepted
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_pop) begin
            r_out_data  <= fifo_rd_data;
            r_out_valid <= 1'b1;
            r_out_last  <= w_final_beat;
        end else if (w_slot_free) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_burst_reader
//  Description : Self-checking bench for fifo_burst_reader. Contains a FIFO
//                model and a stream scoreboard. The scoreboard expects the
//                written words in order, with last on every 8th word.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_reader;

    localparam int c_W   = 32;
    localparam int c_BL  = 8;
    localparam int c_THR = 8;

    logic           clk = 1'b0;
    logic           async_reset_n;
    logic [c_W-1:0] fifo_rd_data;
    logic           fifo_empty;
    logic           fifo_almost_empty;
    logic           fifo_rd_en;
    logic [c_W-1:0] out_data;
    logic           out_valid;
    logic           out_last;
    logic           out_ready;
    logic           burst_active;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .WIDTH          (c_W),
        .BURST_LEN      (c_BL),
        .TIMEOUT_CYCLES (64)
    ) u_dut (
        .clk               (clk),
        .async_reset_n     (async_reset_n),
        .fifo_rd_data      (fifo_rd_data),
        .fifo_empty        (fifo_empty),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_rd_en        (fifo_rd_en),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_last          (out_last),
        .out_ready         (out_ready),
        .burst_active      (burst_active)
    );

    // ---------------- FIFO model (almost-empty threshold 8) ----------------
    logic [c_W-1:0] mem [0:4095];
    logic [11:0]    wr_ptr = '0;
    logic [11:0]    rd_ptr = '0;
    logic           wr_req = 1'b0;
    logic [c_W-1:0] wr_data = '0;
    logic           force_empty = 1'b0;
    int             cyc = 0;
    logic [11:0]    fill;

    assign fill              = wr_ptr - rd_ptr;
    assign fifo_rd_data      = mem[rd_ptr];
    assign fifo_empty        = force_empty || (fill == 12'd0);
    assign fifo_almost_empty = fill < 12'(c_THR);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en) rd_ptr <= rd_ptr + 12'd1;
        if (wr_req) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 12'd1;
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- stream monitor / scoreboard ----------------
    int          pop_q[$];
    int          acc_total  = 0;
    int          pkt_pops   = 0;
    int          acc_in_pkt = 0;
    bit          gap_due    = 0;
    bit          held_valid = 0;
    bit          prev_pop   = 0;
    bit          flush_mode = 0;
    logic [c_W:0] held;
    logic [11:0] exp_idx = '0;

    always @(negedge clk) begin
        if (!async_reset_n) begin
            // Unaccepted words are discarded; resume from the FIFO head
            exp_idx    = rd_ptr;
            pkt_pops   = 0;
            acc_in_pkt = 0;
            gap_due    = 0;
            held_valid = 0;
            prev_pop   = 0;
        end else begin
            bit gap_now;
            bit exp_last;
            gap_now = gap_due;
            gap_due = 0;
            if (fifo_empty) check_eq("empty_guard", {63'd0, fifo_rd_en}, 64'd0);
            if (prev_pop) check_eq("pop_to_valid", {63'd0, out_valid}, 64'd1);
            if (held_valid)
                check_eq("stall_hold", {31'd0, out_valid, out_last, out_data}, {31'd0, 1'b1, held});
            if (fifo_rd_en) begin
                if (gap_now) check_eq("packet_gap", 64'd1, 64'd0);
                if (!flush_mode && pkt_pops == 0)
                    check_eq("burst_start_level", {63'd0, fill >= 12'(c_THR)}, 64'd1);
                pop_q.push_back(cyc);
                pkt_pops++;
                if (flush_mode || pkt_pops == c_BL) begin
                    pkt_pops = 0;
                    gap_due  = 1;
                end
            end
            prev_pop = fifo_rd_en;
            if (out_valid && out_ready) begin
                exp_last = flush_mode || (acc_in_pkt == c_BL - 1);
                check_eq("out_data", {32'd0, out_data}, {32'd0, mem[exp_idx]});
                check_eq("out_last", {63'd0, out_last}, {63'd0, exp_last});
                exp_idx    = exp_idx + 12'd1;
                acc_total++;
                acc_in_pkt = exp_last ? 0 : acc_in_pkt + 1;
            end
            held_valid = out_valid && !out_ready;
            held       = {out_last, out_data};
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic write_word();
        wr_req  = 1'b1;
        wr_data = $urandom;
        step();
        wr_req  = 1'b0;
    endtask

    task automatic wait_pops(input int target, input int budget);
        for (int i = 0; i < budget && pop_q.size() < target; i++) step();
        if (pop_q.size() < target) check_eq("wait_timeout", 64'(pop_q.size()), 64'(target));
    endtask

    int base, p, acc0, wr0;
    logic [11:0] f0;
    int t3;

    initial begin
        async_reset_n = 1'b0;
        out_ready     = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("reset_valid", {63'd0, out_valid}, 64'd0);
        check_eq("reset_last",  {63'd0, out_last}, 64'd0);
        check_eq("reset_data",  {32'd0, out_data}, 64'd0);
        check_eq("reset_rd_en", {63'd0, fifo_rd_en}, 64'd0);
        check_eq("reset_active", {63'd0, burst_active}, 64'd0);
        async_reset_n = 1'b1;
        step();

        // Threshold start: 7 words never start a burst, the 8th does
        out_ready = 1'b1;
        base = pop_q.size();
        acc0 = acc_total;
        repeat (7) write_word();
        repeat (10) step();
        check_eq("thr_no_pop_below", 64'(pop_q.size() - base), 64'd0);
        write_word();
        wait_pops(base + 8, 50);
        repeat (4) step();
        check_eq("thr_pop_count", 64'(pop_q.size() - base), 64'd8);
        if (pop_q.size() >= base + 8)
            check_eq("thr_consecutive", 64'(pop_q[base+7] - pop_q[base]), 64'd7);
        check_eq("thr_fifo_empty", 64'(fill), 64'd0);
        check_eq("thr_accepted", 64'(acc_total - acc0), 64'd8);

        // Backpressure mid-burst
        base = pop_q.size();
        acc0 = acc_total;
        repeat (8) write_word();
        wait_pops(base + 3, 50);
        out_ready = 1'b0;
        p  = pop_q.size();
        f0 = fill;
        repeat (5) step();
        check_eq("bp_no_pops", 64'(pop_q.size() - p), 64'd0);
        check_eq("bp_fill_held", 64'(fill), 64'(f0));
        out_ready = 1'b1;
        wait_pops(base + 8, 50);
        repeat (4) step();
        check_eq("bp_accepted", 64'(acc_total - acc0), 64'd8);
        check_eq("bp_fifo_empty", 64'(fill), 64'd0);

        // Back-to-back: 16 preloaded words form two packets one gap apart
        out_ready = 1'b0;
        base = pop_q.size();
        acc0 = acc_total;
        repeat (16) write_word();
        out_ready = 1'b1;
        wait_pops(base + 16, 100);
        repeat (4) step();
        check_eq("b2b_pop_count", 64'(pop_q.size() - base), 64'd16);
        if (pop_q.size() >= base + 16) begin
            check_eq("b2b_gap", 64'(pop_q[base+8] - pop_q[base+7]), 64'd2);
            check_eq("b2b_second_run", 64'(pop_q[base+15] - pop_q[base+8]), 64'd7);
        end
        check_eq("b2b_accepted", 64'(acc_total - acc0), 64'd16);

        // Empty guard: flag forced empty mid-burst
        out_ready = 1'b0;
        base = pop_q.size();
        acc0 = acc_total;
        repeat (8) write_word();
        wait_pops(base + 1, 20);
        force_empty = 1'b1;
        out_ready   = 1'b1;
        p = pop_q.size();
        repeat (6) step();
        check_eq("eg_no_pops", 64'(pop_q.size() - p), 64'd0);
        check_eq("eg_stay_burst", {63'd0, burst_active}, 64'd1);
        force_empty = 1'b0;
        wait_pops(base + 8, 50);
        repeat (4) step();
        check_eq("eg_accepted", 64'(acc_total - acc0), 64'd8);

        // Reset mid-stream, between edges
        base = pop_q.size();
        repeat (8) write_word();
        wait_pops(base + 3, 50);
        async_reset_n = 1'b0;
        #1;
        check_eq("rst_mid_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_mid_last",  {63'd0, out_last}, 64'd0);
        check_eq("rst_mid_rd_en", {63'd0, fifo_rd_en}, 64'd0);
        repeat (2) step();
        async_reset_n = 1'b1;
        step();
        check_eq("rst_idle_after", {63'd0, burst_active}, 64'd0);
        base = pop_q.size();
        acc0 = acc_total;
        repeat (3) write_word();
        wait_pops(base + 8, 50);
        repeat (4) step();
        check_eq("rst_resume_accepted", 64'(acc_total - acc0), 64'd8);
        check_eq("rst_resume_empty", 64'(fill), 64'd0);

        // Randomised traffic and backpressure
        acc0 = acc_total;
        wr0  = int'(wr_ptr);
        for (int i = 0; i < 1500; i++) begin
            wr_req    = ($urandom_range(0, 99) < 40);
            wr_data   = $urandom;
            out_ready = ($urandom_range(0, 99) < 70);
            step();
        end
        wr_req    = 1'b0;
        out_ready = 1'b1;
        repeat (40) step();
        while (fill != 12'd0 && fill < 12'(c_THR)) write_word();
        repeat (40) step();
        check_eq("rand_drained", 64'(fill), 64'd0);
        check_eq("rand_all_accepted", 64'(acc_total - acc0), 64'(int'(wr_ptr) - wr0));

`ifdef FIFO_BURST_READER_TIMEOUT_EN
        // Residual words flush as single-beat packets after the idle timeout
        flush_mode = 1;
        base = pop_q.size();
        acc0 = acc_total;
        repeat (3) write_word();
        t3 = cyc;
        wait_pops(base + 3, 200);
        repeat (4) step();
        check_eq("to_pop_count", 64'(pop_q.size() - base), 64'd3);
        if (pop_q.size() >= base + 3) begin
            check_eq("to_delay_window",
                     {63'd0, (pop_q[base] - t3 >= 60) && (pop_q[base] - t3 <= 66)}, 64'd1);
            check_eq("to_spacing", 64'(pop_q[base+1] - pop_q[base]), 64'd2);
        end
        check_eq("to_accepted", 64'(acc_total - acc0), 64'd3);
        flush_mode = 0;
`else
        // Without the timeout, residual words wait indefinitely
        base = pop_q.size();
        repeat (3) write_word();
        t3 = cyc;
        repeat (1000) step();
        check_eq("no_to_no_pops", 64'(pop_q.size() - base), 64'd0);
        check_eq("no_to_fill", 64'(fill), 64'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
